// File: rtl/ccd_pattern_source.sv
// ccd_pattern_source: synthetic CCD pixel stream (FVAL/DVAL, X/Y, 12-bit RGB) with test patterns.
// One pixel per clock; every output comes straight from a register.
module ccd_pattern_source #(
    parameter int          H_ACTIVE  = 800,
    parameter int          V_ACTIVE  = 480,
    parameter int          H_BLANK   = 16,
    parameter int          V_BLANK   = 64,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        iCLK,
    input  logic        iReset_n,
    input  logic        iStart,
    input  logic        iStop,
    input  logic        iSingle,
    input  logic [1:0]  iPattern,
    output logic        oFval,
    output logic        oDval,
    output logic [15:0] oX_Cont,
    output logic [15:0] oY_Cont,
    output logic [11:0] oRed,
    output logic [11:0] oGreen,
    output logic [11:0] oBlue,
    output logic [31:0] oFrame_Cont,
    output logic        oBusy
);
    localparam logic [15:0] H_LAST  = 16'(H_ACTIVE - 1);
    localparam logic [15:0] V_LAST  = 16'(V_ACTIVE - 1);
    localparam logic [15:0] HB_LAST = 16'(H_BLANK - 1);
    localparam logic [15:0] VB_LAST = 16'(V_BLANK - 1);
    localparam logic [15:0] BAR_W   = 16'((H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1);

    typedef enum logic [1:0] {IDLE, VBLANK, ACTIVE, HBLANK} state_t;
    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d, x_q, x_d, y_q, y_d, lfsr_q, lfsr_d, l_cur;
    logic [31:0] frame_q, frame_d;
    logic [11:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic [1:0]  pat_q, pat_d;
    logic [2:0]  bar;
    logic        single_q, single_d, stop_q, stop_d, fval_q, fval_d, dval_q, dval_d, busy_q, chk;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        y_d      = y_q;
        pat_d    = pat_q;
        single_d = single_q;
        stop_d   = stop_q | (iStop && state_q != IDLE);
        fval_d   = fval_q;
        dval_d   = 1'b0;
        frame_d  = frame_q;
        l_cur    = lfsr_q;
        case (state_q)
            IDLE: if (iStart && !iStop) begin
                state_d  = VBLANK;
                cnt_d    = '0;
                single_d = iSingle;
            end
            VBLANK: if (cnt_q == VB_LAST) begin
                state_d = ACTIVE;
                pat_d   = iPattern;
                l_cur   = LFSR_SEED;
                x_d     = '0;
                y_d     = '0;
                fval_d  = 1'b1;
                dval_d  = 1'b1;
            end else cnt_d = cnt_q + 16'd1;
            ACTIVE: if (x_q == H_LAST) begin
                state_d = HBLANK;
                cnt_d   = '0;
                x_d     = '0;
            end else begin
                x_d    = x_q + 16'd1;
                dval_d = 1'b1;
            end
            HBLANK: if (cnt_q != HB_LAST) cnt_d = cnt_q + 16'd1;
            else if (y_q == V_LAST) begin
                frame_d = frame_q + 32'd1;
                fval_d  = 1'b0;
                cnt_d   = '0;
                state_d = (stop_q || single_q) ? IDLE : VBLANK;
            end else begin
                y_d     = y_q + 16'd1;
                state_d = ACTIVE;
                dval_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (state_d == IDLE) stop_d = 1'b0;
        // colour is computed from the pixel about to be presented, so it uses next-state X/Y/pattern
        lfsr_d = dval_d ? {l_cur[14:0], l_cur[15] ^ l_cur[13] ^ l_cur[12] ^ l_cur[10]} : l_cur;
        bar    = 3'(x_d / BAR_W);
        chk    = x_d[3] ^ y_d[3];
        r_d = !dval_d ? 12'h000 : pat_d == 2'd0 ? {x_d[7:0], 4'b0} : pat_d == 2'd1 ? {12{bar[2]}} :
              pat_d == 2'd2 ? {12{chk}} : l_cur[11:0];
        g_d = !dval_d ? 12'h000 : pat_d == 2'd0 ? {x_d[7:0], 4'b0} : pat_d == 2'd1 ? {12{bar[1]}} :
              pat_d == 2'd2 ? {12{chk}} : l_cur[15:4];
        b_d = !dval_d ? 12'h000 : pat_d == 2'd0 ? {x_d[7:0], 4'b0} : pat_d == 2'd1 ? {12{bar[0]}} :
              pat_d == 2'd2 ? {12{chk}} : {l_cur[7:0], l_cur[15:12]};
    end

    always_ff @(posedge iCLK or negedge iReset_n) begin
        if (!iReset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            pat_q    <= '0;
            single_q <= 1'b0;
            stop_q   <= 1'b0;
            fval_q   <= 1'b0;
            dval_q   <= 1'b0;
            frame_q  <= '0;
            lfsr_q   <= LFSR_SEED;
            r_q      <= '0;
            g_q      <= '0;
            b_q      <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            y_q      <= y_d;
            pat_q    <= pat_d;
            single_q <= single_d;
            stop_q   <= stop_d;
            fval_q   <= fval_d;
            dval_q   <= dval_d;
            frame_q  <= frame_d;
            lfsr_q   <= lfsr_d;
            r_q      <= r_d;
            g_q      <= g_d;
            b_q      <= b_d;
            busy_q   <= state_d != IDLE;
        end
    end

    assign oFval       = fval_q;
    assign oDval       = dval_q;
    assign oX_Cont     = x_q;
    assign oY_Cont     = y_q;
    assign oRed        = r_q;
    assign oGreen      = g_q;
    assign oBlue       = b_q;
    assign oFrame_Cont = frame_q;
    assign oBusy       = busy_q;
endmodule

// File: tb/tb_ccd_pattern_source.sv
// tb_ccd_pattern_source: directed tests of a small (8x4) and a full-size (800x480) pattern source.
module tb_ccd_pattern_source;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0, single = 1'b0;
    logic [1:0]  pat = 2'd0;
    logic        s_fval, s_dval, s_busy, b_fval, b_dval, b_busy;
    logic [15:0] s_x, s_y, b_x, b_y;
    logic [11:0] s_r, s_g, s_b, b_r, b_g, b_b;
    logic [31:0] s_frame, b_frame;
    int vectors = 0, errors = 0, proto_err = 0;

    always #5 clk = ~clk;

    ccd_pattern_source #(.H_ACTIVE(8), .V_ACTIVE(4), .H_BLANK(2), .V_BLANK(3)) u_small (
        .iCLK(clk), .iReset_n(rst_n), .iStart(start), .iStop(stop), .iSingle(single), .iPattern(pat),
        .oFval(s_fval), .oDval(s_dval), .oX_Cont(s_x), .oY_Cont(s_y), .oRed(s_r), .oGreen(s_g),
        .oBlue(s_b), .oFrame_Cont(s_frame), .oBusy(s_busy));

    ccd_pattern_source u_big (
        .iCLK(clk), .iReset_n(rst_n), .iStart(start), .iStop(stop), .iSingle(single), .iPattern(pat),
        .oFval(b_fval), .oDval(b_dval), .oX_Cont(b_x), .oY_Cont(b_y), .oRed(b_r), .oGreen(b_g),
        .oBlue(b_b), .oFrame_Cont(b_frame), .oBusy(b_busy));

    always @(negedge clk) if (rst_n) begin
        if (s_dval && (!s_fval || s_x >= 16'd8 || s_y >= 16'd4)) proto_err++;
        if (b_dval && (!b_fval || b_x >= 16'd800 || b_y >= 16'd480)) proto_err++;
    end

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; stop = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_start(input logic sgl, input logic [1:0] p);
        single = sgl; pat = p; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        int bad;
        @(negedge clk);
        vectors++;
        if ({s_fval, s_dval, s_x, s_y, s_r, s_g, s_b, s_frame, s_busy} !== '0) begin
            errors++; $display("FAIL reset_state: small outputs nonzero, busy=%0b x=%0d", s_busy, s_x);
        end
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start(1'b0, 2'd0);
        repeat (5) @(negedge clk);
        vectors++;
        if (s_dval !== 1'b1) begin errors++; $display("FAIL mid_active: dval=%0b want 1", s_dval); end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({s_fval, s_dval, s_x, s_y, s_r, s_g, s_b, s_frame, s_busy} !== '0 ||
            {b_fval, b_dval, b_x, b_y, b_r, b_g, b_b, b_frame, b_busy} !== '0) begin
            errors++; $display("FAIL async_reset: got dval=%0b x=%0d r=%h busy=%0b want all 0", s_dval, s_x, s_r, s_busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (s_dval || s_busy || b_dval || b_busy) bad++;
        end
        vectors++;
        if (bad != 0) begin errors++; $display("FAIL after_reset_idle: %0d active cycles want 0", bad); end
    endtask

    task automatic test_single_frame();
        int first, done, pix;
        first = -1; done = -1; pix = 0;
        do_reset();
        pulse_start(1'b1, 2'd0);
        vectors++;
        if (s_busy !== 1'b1 || s_dval !== 1'b0) begin
            errors++; $display("FAIL busy_after_start: busy=%0b dval=%0b want 1/0", s_busy, s_dval);
        end
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (s_dval) begin
                if (first < 0) first = n;
                vectors++;
                if (s_x !== 16'(pix % 8) || s_y !== 16'(pix / 8) || {s_r, s_g, s_b} !== {3{12'((pix % 8) * 16)}}) begin
                    errors++;
                    $display("FAIL ramp_pixel%0d: x=%0d y=%0d rgb=%h/%h/%h want x=%0d y=%0d r=%0d", pix, s_x, s_y,
                             s_r, s_g, s_b, pix % 8, pix / 8, (pix % 8) * 16);
                end
                if (pix == 0) pat = 2'd3;
                pix++;
            end
            if (!s_busy) begin done = n; break; end
        end
        vectors++;
        if (first != 3) begin errors++; $display("FAIL first_dval_latency: got %0d want 3", first); end
        vectors++;
        if (done != 43) begin errors++; $display("FAIL idle_latency: got %0d want 43", done); end
        vectors++;
        if (pix != 32) begin errors++; $display("FAIL pixel_count: got %0d want 32", pix); end
        vectors++;
        if (s_frame !== 32'd1) begin errors++; $display("FAIL frame_count_single: got %0d want 1", s_frame); end
    endtask

    task automatic test_start_stop_idle();
        do_reset();
        stop = 1'b1;
        pulse_start(1'b0, 2'd0);
        stop = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (s_busy !== 1'b0 || b_busy !== 1'b0) begin
            errors++; $display("FAIL start_with_stop: busy=%0b/%0b want 0/0", s_busy, b_busy);
        end
    endtask

    task automatic test_stop();
        int done, pix;
        done = -1; pix = 0;
        do_reset();
        pulse_start(1'b0, 2'd0);
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            stop = (n == 60);
            if (s_dval) pix++;
            if (!s_busy) begin done = n; break; end
        end
        stop = 1'b0;
        vectors++;
        if (done != 86) begin errors++; $display("FAIL stop_idle_time: got %0d want 86", done); end
        vectors++;
        if (s_frame !== 32'd2) begin errors++; $display("FAIL stop_frame_count: got %0d want 2", s_frame); end
        vectors++;
        if (pix != 64) begin errors++; $display("FAIL stop_pixel_count: got %0d want 64", pix); end
    endtask

    task automatic test_lfsr();
        logic [35:0] f1 [32];
        int pix;
        pix = 0;
        do_reset();
        pulse_start(1'b0, 2'd3);
        for (int n = 1; n <= 200 && pix < 64; n++) begin
            @(negedge clk);
            if (s_dval) begin
                if (pix % 32 == 0) begin
                    vectors++;
                    if ({s_r, s_g, s_b} !== 36'hCE1_ACE_E1A) begin
                        errors++; $display("FAIL lfsr_first_pixel%0d: got %h/%h/%h want CE1/ACE/E1A", pix, s_r, s_g, s_b);
                    end
                end
                if (pix == 1) begin
                    vectors++;
                    if ({s_r, s_g, s_b} !== 36'h9C3_59C_C35) begin
                        errors++; $display("FAIL lfsr_second_pixel: got %h/%h/%h want 9C3/59C/C35", s_r, s_g, s_b);
                    end
                end
                if (pix < 32) f1[pix] = {s_r, s_g, s_b};
                else begin
                    vectors++;
                    if ({s_r, s_g, s_b} !== f1[pix - 32]) begin
                        errors++; $display("FAIL lfsr_repeat%0d: got %h want %h", pix - 32, {s_r, s_g, s_b}, f1[pix - 32]);
                    end
                end
                pix++;
            end
        end
        vectors++;
        if (pix != 64) begin errors++; $display("FAIL lfsr_pixels: got %0d want 64", pix); end
    endtask

    task automatic test_bars();
        int seen;
        seen = 0;
        do_reset();
        pulse_start(1'b1, 2'd1);
        for (int n = 1; n <= 1000; n++) begin
            @(negedge clk);
            if (b_dval && b_y == 16'd0) begin
                if (b_x == 16'd99 || b_x == 16'd100 || b_x == 16'd400 || b_x == 16'd799) begin
                    vectors++; seen++;
                    if ({b_r, b_g, b_b} !== (b_x == 16'd99 ? 36'h000_000_000 : b_x == 16'd100 ? 36'h000_000_FFF :
                                             b_x == 16'd400 ? 36'hFFF_000_000 : 36'hFFF_FFF_FFF)) begin
                        errors++; $display("FAIL bars_x%0d: got %h/%h/%h", b_x, b_r, b_g, b_b);
                    end
                end
                if (b_x == 16'd799) break;
            end
        end
        vectors++;
        if (seen != 4) begin errors++; $display("FAIL bars_seen: got %0d want 4", seen); end
    endtask

    task automatic test_checker();
        int seen;
        seen = 0;
        do_reset();
        pulse_start(1'b1, 2'd2);
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (b_dval && b_y == 16'd0 && (b_x == 16'd0 || b_x == 16'd8 || b_x == 16'd16 || b_x == 16'd24)) begin
                vectors++; seen++;
                if ({b_r, b_g, b_b} !== {3{(b_x == 16'd8 || b_x == 16'd24) ? 12'hFFF : 12'h000}}) begin
                    errors++; $display("FAIL checker_x%0d: got %h/%h/%h", b_x, b_r, b_g, b_b);
                end
                if (b_x == 16'd24) break;
            end
        end
        vectors++;
        if (seen != 4) begin errors++; $display("FAIL checker_seen: got %0d want 4", seen); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_start_stop_idle();
        test_stop();
        test_lfsr();
        test_bars();
        test_checker();
        vectors++;
        if (proto_err != 0) begin errors++; $display("FAIL protocol: %0d violations want 0", proto_err); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
